// File: rtl/hit_manager.sv
// Player hit bookkeeping: folds per-pixel collision flags into at most one hit
// per video frame, tracks lives, post-hit invulnerability and game-over.
module hit_manager #(
  parameter int INIT_LIVES   = 3,
  parameter int LIVES_W      = 3,
  parameter int GRACE_FRAMES = 60,
  parameter int GRACE_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic               start,
  output logic               hit_pulse,
  output logic [LIVES_W-1:0] lives,
  output logic [7:0]         hit_count,
  output logic               invulnerable,
  output logic               game_over,
  output logic               playing,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GRACE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [LIVES_W-1:0] INIT_L  = LIVES_W'(INIT_LIVES);
  localparam logic [GRACE_W-1:0] GRACE_L = GRACE_W'(GRACE_FRAMES);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [7:0]         hit_count_q, hit_count_d;
  logic [GRACE_W-1:0] grace_cnt_q, grace_cnt_d;
  logic               frame_hit_q, frame_hit_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               invulnerable_q, invulnerable_d;
  logic               game_over_q, game_over_d;
  logic               playing_q, playing_d;

  // State register: every flop, including the registered output decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lives_q        <= INIT_L;
      hit_count_q    <= 8'd0;
      grace_cnt_q    <= '0;
      frame_hit_q    <= 1'b0;
      hit_pulse_q    <= 1'b0;
      invulnerable_q <= 1'b0;
      game_over_q    <= 1'b0;
      playing_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      hit_count_q    <= hit_count_d;
      grace_cnt_q    <= grace_cnt_d;
      frame_hit_q    <= frame_hit_d;
      hit_pulse_q    <= hit_pulse_d;
      invulnerable_q <= invulnerable_d;
      game_over_q    <= game_over_d;
      playing_q      <= playing_d;
    end
  end

  // Next-state and datapath updates. A frame's hit is judged on the strobe
  // that closes it, using the accumulator value from before that edge.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    hit_count_d = hit_count_q;
    grace_cnt_d = grace_cnt_q;
    hit_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_PLAY;
          lives_d     = INIT_L;
          hit_count_d = 8'd0;
          grace_cnt_d = '0;
        end
      end
      ST_PLAY: begin
        if (startOfFrame && frame_hit_q) begin
          hit_pulse_d = 1'b1;
          hit_count_d = (hit_count_q == 8'hFF) ? 8'hFF : hit_count_q + 8'd1;
          if (lives_q <= LIVES_W'(1)) begin
            state_d = ST_OVER;
            lives_d = '0;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
            if (GRACE_FRAMES != 0) begin
              state_d     = ST_GRACE;
              grace_cnt_d = GRACE_L;
            end
          end
        end
      end
      ST_GRACE: begin
        if (startOfFrame) begin
          if (grace_cnt_q <= GRACE_W'(1)) begin
            state_d     = ST_PLAY;
            grace_cnt_d = '0;
          end else begin
            grace_cnt_d = grace_cnt_q - GRACE_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A collision on the strobe cycle belongs to the frame just starting.
    frame_hit_d = frame_hit_q;
    if (startOfFrame) begin
      frame_hit_d = collision && (state_d == ST_PLAY);
    end else if (collision && (state_q == ST_PLAY)) begin
      frame_hit_d = 1'b1;
    end
  end

  // Output decode from the upcoming state so the flags are plain flops.
  always_comb begin
    invulnerable_d = (state_d == ST_GRACE);
    game_over_d    = (state_d == ST_OVER);
    playing_d      = (state_d == ST_PLAY) || (state_d == ST_GRACE);
  end

  assign hit_pulse    = hit_pulse_q;
  assign lives        = lives_q;
  assign hit_count    = hit_count_q;
  assign invulnerable = invulnerable_q;
  assign game_over    = game_over_q;
  assign playing      = playing_q;
  assign state_dbg    = state_q;

endmodule
